imm_gen_pipe: RTL and testbench

//  Registered immediate generator for the decode stage. Accepts an instruction and its PC

---
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe.sv | 107 ++++++++++
 tb/tb_imm_gen_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute bus for the immediate generator: instruction/PC in, immediate/target out.
// valid/ready: a beat moves on a rising edge where valid and ready are both high; the source keeps
// valid and payload stable until then and never waits on ready before raising valid.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int SRC_W = 3
);
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;
    logic [SRC_W-1:0] imm_src_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  imm_op_o;
    logic [XLEN-1:0]  target_o;
    logic             illegal_o;

    modport master (
        output valid_i, instr_i, pc_i, imm_src_i, ready_i,
        input  ready_o, valid_o, imm_op_o, target_o, illegal_o
    );

    modport slave (
        input  valid_i, instr_i, pc_i, imm_src_i, ready_i,
        output ready_o, valid_o, imm_op_o, target_o, illegal_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer; emits the extended immediate,
// the PC-relative target and an illegal-format flag per accepted instruction.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int SRC_W = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    imm_gen_pipe_if.slave bus,
    output logic [1:0]    state_o
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [SRC_W-1:0] SRC_I = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_S = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_B = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_J = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_U = SRC_W'(4);
    localparam logic [SRC_W-1:0] SRC_Z = SRC_W'(5);

    logic [1:0]      state;
    logic [XLEN-1:0] new_imm, new_tgt;
    logic            new_ill;
    logic [XLEN-1:0] out_imm, out_tgt, skid_imm, skid_tgt;
    logic            out_ill, skid_ill;
    logic            xfer_in, xfer_out;

    // Size casts of signed fields sign-extend to XLEN, so one expression serves XLEN 32 and 64.
    always_comb begin
        new_imm = '0;
        new_ill = 1'b0;
        case (bus.imm_src_i)
            SRC_I: new_imm = XLEN'($signed(bus.instr_i[31:20]));
            SRC_S: new_imm = XLEN'($signed({bus.instr_i[31:25], bus.instr_i[11:7]}));
            SRC_B: new_imm = XLEN'($signed({bus.instr_i[31], bus.instr_i[7], bus.instr_i[30:25],
                                            bus.instr_i[11:8], 1'b0}));
            SRC_J: new_imm = XLEN'($signed({bus.instr_i[31], bus.instr_i[19:12], bus.instr_i[20],
                                            bus.instr_i[30:21], 1'b0}));
            SRC_U: new_imm = XLEN'($signed({bus.instr_i[31:12], 12'b0}));
            SRC_Z: new_imm = XLEN'(bus.instr_i[19:15]);
            default: new_ill = 1'b1;
        endcase
        new_tgt = bus.pc_i + new_imm;
    end

    assign bus.ready_o   = (state != FULL);
    assign bus.valid_o   = (state != EMPTY);
    assign bus.imm_op_o  = out_imm;
    assign bus.target_o  = out_tgt;
    assign bus.illegal_o = out_ill;
    assign state_o       = state;

    assign xfer_in  = bus.valid_i && bus.ready_o;
    assign xfer_out = bus.valid_o && bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= EMPTY;
            out_imm  <= '0;
            out_tgt  <= '0;
            out_ill  <= 1'b0;
            skid_imm <= '0;
            skid_tgt <= '0;
            skid_ill <= 1'b0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        out_imm <= new_imm;
                        out_tgt <= new_tgt;
                        out_ill <= new_ill;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        out_imm <= new_imm;
                        out_tgt <= new_tgt;
                        out_ill <= new_ill;
                    end else if (xfer_in) begin
                        skid_imm <= new_imm;
                        skid_tgt <= new_tgt;
                        skid_ill <= new_ill;
                        state    <= FULL;
                    end else if (xfer_out) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Output register drains first; skid entry moves up behind it.
                    if (bus.ready_i) begin
                        out_imm <= skid_imm;
                        out_tgt <= skid_tgt;
                        out_ill <= skid_ill;
                        state   <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats, latency, backpressure, flush, reset and XLEN=64.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [1:0] state32, state64;

    int n_checks = 0;
    int n_errors = 0;
    logic [64:0] exp_q[$];

    imm_gen_pipe_if #(.XLEN(32), .SRC_W(3)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .SRC_W(3)) b64 ();

    imm_gen_pipe #(.XLEN(32), .SRC_W(3)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b32), .state_o(state32)
    );
    imm_gen_pipe #(.XLEN(64), .SRC_W(3)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b64), .state_o(state64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] pc);
        b32.valid_i   = 1'b1;
        b32.instr_i   = instr;
        b32.imm_src_i = src;
        b32.pc_i      = pc;
    endtask

    task automatic push32(input logic [31:0] imm, input logic [31:0] tgt, input logic ill);
        exp_q.push_back({imm, tgt, ill});
    endtask

    // Single transfer from EMPTY with ready_i high: one-cycle latency, then drained.
    task automatic run_one32(input string tag, input logic [31:0] instr, input logic [2:0] src,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] tgt, input logic ill);
        b32.ready_i = 1'b1;
        check({tag, "_pre_valid"}, 64'(b32.valid_o), 64'd0);
        drive32(instr, src, pc);
        push32(imm, tgt, ill);
        tick();
        b32.valid_i = 1'b0;
        check({tag, "_valid"}, 64'(b32.valid_o), 64'd1);
        check({tag, "_imm"}, 64'(b32.imm_op_o), 64'(imm));
        check({tag, "_tgt"}, 64'(b32.target_o), 64'(tgt));
        check({tag, "_ill"}, 64'(b32.illegal_o), 64'(ill));
        tick();
    endtask

    task automatic run_one64(input string tag, input logic [31:0] instr, input logic [2:0] src,
                             input logic [63:0] pc, input logic [63:0] imm,
                             input logic [63:0] tgt);
        b64.valid_i   = 1'b1;
        b64.instr_i   = instr;
        b64.imm_src_i = src;
        b64.pc_i      = pc;
        tick();
        b64.valid_i = 1'b0;
        check({tag, "_valid"}, 64'(b64.valid_o), 64'd1);
        check({tag, "_imm"}, b64.imm_op_o, imm);
        check({tag, "_tgt"}, b64.target_o, tgt);
        tick();
    endtask

    // Scoreboard: an output beat is taken at the next rising edge when valid_o && ready_i.
    always @(negedge clk) begin
        logic [64:0] item;
        if (!rst && !flush && b32.valid_o && b32.ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_beat", 64'd1, 64'd0);
            end else begin
                item = exp_q.pop_front();
                check("sb_imm", 64'(b32.imm_op_o), 64'(item[64:33]));
                check("sb_tgt", 64'(b32.target_o), 64'(item[32:1]));
                check("sb_ill", 64'(b32.illegal_o), 64'(item[0]));
            end
        end
    end

    initial begin
        b32.valid_i = 1'b0; b32.instr_i = '0; b32.pc_i = '0; b32.imm_src_i = '0; b32.ready_i = 1'b1;
        b64.valid_i = 1'b0; b64.instr_i = '0; b64.pc_i = '0; b64.imm_src_i = '0; b64.ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(b32.valid_o), 64'd0);
        check("rst_ready", 64'(b32.ready_o), 64'd1);
        check("rst_imm", 64'(b32.imm_op_o), 64'd0);
        check("rst_tgt", 64'(b32.target_o), 64'd0);
        check("rst_ill", 64'(b32.illegal_o), 64'd0);
        check("rst64_valid", 64'(b64.valid_o), 64'd0);

        // Formats
        run_one32("fmt_i", 32'hFFF00093, 3'b000, 32'h0,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_one32("fmt_s", 32'hFE000C23, 3'b001, 32'h0,    32'hFFFFFFF8, 32'hFFFFFFF8, 1'b0);
        run_one32("fmt_b", 32'hFE000EE3, 3'b010, 32'h100,  32'hFFFFFFFC, 32'h000000FC, 1'b0);
        run_one32("fmt_j", 32'h008000EF, 3'b011, 32'h1000, 32'h00000008, 32'h00001008, 1'b0);
        run_one32("fmt_u", 32'h123450B7, 3'b100, 32'h10,   32'h12345000, 32'h12345010, 1'b0);
        run_one32("fmt_z", 32'hFFFF8073, 3'b101, 32'h20,   32'h0000001F, 32'h0000003F, 1'b0);
        run_one32("ill_6", 32'hFFF00093, 3'b110, 32'h44,   32'h0,        32'h44,       1'b1);
        run_one32("ill_7", 32'hFFF00093, 3'b111, 32'h48,   32'h0,        32'h48,       1'b1);

        // Backpressure: A, B fill the buffer, C must wait
        b32.ready_i = 1'b0;
        drive32(32'h00100093, 3'b000, 32'h100); push32(32'h1, 32'h101, 1'b0);
        tick();
        check("bp_ready_one", 64'(b32.ready_o), 64'd1);
        drive32(32'h00200093, 3'b000, 32'h100); push32(32'h2, 32'h102, 1'b0);
        tick();
        check("bp_ready_full", 64'(b32.ready_o), 64'd0);
        check("bp_state_full", 64'(state32), 64'd2);
        drive32(32'h00300093, 3'b000, 32'h100); push32(32'h3, 32'h103, 1'b0);
        tick();
        check("bp_hold_ready", 64'(b32.ready_o), 64'd0);
        check("bp_hold_imm", 64'(b32.imm_op_o), 64'h1);
        b32.ready_i = 1'b1;
        tick();
        check("bp_b_imm", 64'(b32.imm_op_o), 64'h2);
        check("bp_ready_back", 64'(b32.ready_o), 64'd1);
        tick();
        b32.valid_i = 1'b0;
        check("bp_c_imm", 64'(b32.imm_op_o), 64'h3);
        tick();
        check("bp_drained", 64'(b32.valid_o), 64'd0);

        // Full throughput with ready_i held high
        for (int i = 0; i < 4; i++) begin
            drive32(32'(((i + 4) << 20) | 32'h93), 3'b000, 32'h200);
            push32(32'(i + 4), 32'(32'h200 + i + 4), 1'b0);
            tick();
            check("tp_ready", 64'(b32.ready_o), 64'd1);
        end
        b32.valid_i = 1'b0;
        tick();
        check("tp_drained", 64'(b32.valid_o), 64'd0);

        // Flush in FULL with a new input offered; none of these may appear
        b32.ready_i = 1'b0;
        drive32(32'h00D00093, 3'b000, 32'h0);
        tick();
        drive32(32'h00E00093, 3'b000, 32'h0);
        tick();
        check("fl_state_full", 64'(state32), 64'd2);
        drive32(32'h00F00093, 3'b000, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        b32.valid_i = 1'b0;
        check("fl_valid", 64'(b32.valid_o), 64'd0);
        check("fl_ready", 64'(b32.ready_o), 64'd1);
        b32.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_quiet", 64'(b32.valid_o), 64'd0);
        end
        run_one32("fl_after", 32'h02A00093, 3'b000, 32'h10, 32'h2A, 32'h3A, 1'b0);

        // Reset while FULL drops everything
        b32.ready_i = 1'b0;
        drive32(32'hFFF00093, 3'b000, 32'h0);
        tick();
        drive32(32'hFFE00093, 3'b000, 32'h0);
        tick();
        check("rm_state_full", 64'(state32), 64'd2);
        b32.valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_valid", 64'(b32.valid_o), 64'd0);
        check("rm_ready", 64'(b32.ready_o), 64'd1);
        check("rm_imm", 64'(b32.imm_op_o), 64'd0);
        check("rm_tgt", 64'(b32.target_o), 64'd0);
        check("rm_ill", 64'(b32.illegal_o), 64'd0);
        b32.ready_i = 1'b1;
        tick();
        check("rm_quiet", 64'(b32.valid_o), 64'd0);

        // XLEN=64
        run_one64("x64_i", 32'hFFF00093, 3'b000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        run_one64("x64_u", 32'h123450B7, 3'b100, 64'h10, 64'h0000000012345000, 64'h0000000012345010);
        run_one64("x64_uneg", 32'h800000B7, 3'b100, 64'h1000,
                  64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000);

        tick();
        check("sb_all_out", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
